// File: rtl/hazard_scoreboard.sv
// Shift-register hazard scoreboard: operand forwarding selects, load-use stall and redirect flush.
// Optional stall/redirect counters are built when HAZARD_STATS_EN is defined.
module hazard_scoreboard #(
  parameter int STAGES   = 3,
  parameter int LOAD_LAT = 1,
  parameter int SELW     = $clog2(STAGES + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     id_inst,
  input  logic            id_valid,
  input  logic            ex_redirect,
  output logic [SELW-1:0] rs1_fwd_sel,
  output logic [SELW-1:0] rs2_fwd_sel,
  output logic            stall,
  output logic            flush_if,
  output logic            flush_id,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  logic [6:0] op;
  logic [4:0] rd, rs1, rs2;
  logic       writes_rd, uses_rs1, uses_rs2, is_load;
  logic       unused_inst_bits;

  assign op        = id_inst[6:0];
  assign rd        = id_inst[11:7];
  assign rs1       = id_inst[19:15];
  assign rs2       = id_inst[24:20];
  assign writes_rd = (op != OP_STORE) && (op != OP_BRANCH) && (rd != 5'd0);
  assign uses_rs1  = !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
  assign uses_rs2  = op inside {OP_RTYPE, OP_STORE, OP_BRANCH};
  assign is_load   = (op == OP_LOAD);
  assign unused_inst_bits = ^{id_inst[31:25], id_inst[14:12]};

  // Entry k holds the instruction k stages past decode; non-writers are stored as invalid.
  logic       valid_q [1:STAGES];
  logic [4:0] rd_q    [1:STAGES];
  logic       load_q  [1:STAGES];
  logic       valid_d [1:STAGES];
  logic [4:0] rd_d    [1:STAGES];
  logic       load_d  [1:STAGES];
  logic       issue;

  assign issue = id_valid && !stall && !ex_redirect;

  genvar gi;
  generate
    for (gi = 1; gi <= STAGES; gi++) begin : g_stage
      if (gi == 1) begin : g_head
        assign valid_d[gi] = issue && writes_rd;
        assign rd_d[gi]    = rd;
        assign load_d[gi]  = is_load;
      end else begin : g_shift
        assign valid_d[gi] = valid_q[gi-1];
        assign rd_d[gi]    = rd_q[gi-1];
        assign load_d[gi]  = load_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= STAGES; k++) begin
        valid_q[k] <= 1'b0;
        rd_q[k]    <= 5'd0;
        load_q[k]  <= 1'b0;
      end
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        rd_q[k]    <= rd_d[k];
        load_q[k]  <= load_d[k];
      end
    end
  end

  logic [SELW-1:0] sel1_raw, sel2_raw;
  logic            haz1, haz2;

  // Scan oldest to youngest so the youngest matching producer overwrites the result.
  always_comb begin
    sel1_raw = '0;
    sel2_raw = '0;
    haz1     = 1'b0;
    haz2     = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      if (valid_q[k] && (rd_q[k] == rs1) && uses_rs1 && (rs1 != 5'd0)) begin
        sel1_raw = SELW'(k);
        haz1     = load_q[k] && (k <= LOAD_LAT);
      end
      if (valid_q[k] && (rd_q[k] == rs2) && uses_rs2 && (rs2 != 5'd0)) begin
        sel2_raw = SELW'(k);
        haz2     = load_q[k] && (k <= LOAD_LAT);
      end
    end
  end

  assign stall       = id_valid && !ex_redirect && (haz1 || haz2);
  assign rs1_fwd_sel = stall ? '0 : sel1_raw;
  assign rs2_fwd_sel = stall ? '0 : sel2_raw;
  assign flush_if    = ex_redirect;
  assign flush_id    = ex_redirect;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (ex_redirect && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (LOAD_LAT=1 and LOAD_LAT=2) on shared stimulus,
// directed scenarios plus random traffic against a history-based reference model.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] id_inst = 32'd0;
  logic        id_valid = 1'b0;
  logic        ex_redirect = 1'b0;

  logic [1:0]  a_s1, a_s2, b_s1, b_s2;
  logic        a_stall, a_fif, a_fid, b_stall, b_fif, b_fid;
  logic [31:0] a_sc, a_fc, b_sc, b_fc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.STAGES(3), .LOAD_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .id_valid(id_valid), .ex_redirect(ex_redirect),
    .rs1_fwd_sel(a_s1), .rs2_fwd_sel(a_s2), .stall(a_stall), .flush_if(a_fif), .flush_id(a_fid),
    .stall_cnt(a_sc), .flush_cnt(a_fc)
  );

  hazard_scoreboard #(.STAGES(3), .LOAD_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .id_valid(id_valid), .ex_redirect(ex_redirect),
    .rs1_fwd_sel(b_s1), .rs2_fwd_sel(b_s2), .stall(b_stall), .flush_if(b_fif), .flush_id(b_fid),
    .stall_cnt(b_sc), .flush_cnt(b_fc)
  );

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [31:0] add_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'h00, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] sub_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'h20, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] addi_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] lw_i(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] sw_i(input logic [4:0] rs2, input logic [4:0] rs1);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
  endfunction

  // Apply one transaction on the falling edge and let combinational outputs settle.
  task automatic drive(input logic [31:0] inst, input logic v, input logic r);
    @(negedge clk);
    id_inst = inst; id_valid = v; ex_redirect = r;
    #1;
    $display("[%0t] inst=%h v=%0b redir=%0b | A sel=%0d/%0d st=%0b | B sel=%0d/%0d st=%0b | fl=%0b%0b",
             $time, inst, v, r, a_s1, a_s2, a_stall, b_s1, b_s2, b_stall, a_fif, a_fid);
  endtask

  task automatic drain();
    repeat (3) drive(NOP, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    id_inst = add_i(5'd6, 5'd5, 5'd5); id_valid = 1'b1; ex_redirect = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (a_s1 !== 2'd0 || a_s2 !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d/%0d exp=0/0", a_s1, a_s2); end
    checks++; if (a_stall !== 1'b0 || b_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b/%0b exp=0/0", a_stall, b_stall); end
    checks++; if (a_fif !== 1'b1 || a_fid !== 1'b1) begin errors++; $display("FAIL reset_flush_follows got=%0b/%0b exp=1/1", a_fif, a_fid); end
    checks++; if (a_sc !== 32'd0 || a_fc !== 32'd0) begin errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", a_sc, a_fc); end
    ex_redirect = 1'b0; id_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_forward();
    drive(add_i(5'd5, 5'd1, 5'd2), 1'b1, 1'b0);
    drive(add_i(5'd6, 5'd5, 5'd3), 1'b1, 1'b0);
    checks++; if (a_s1 !== 2'd1 || a_s2 !== 2'd0 || a_stall !== 1'b0) begin errors++; $display("FAIL fwd_ex_A got=%0d/%0d st=%0b exp=1/0 st=0", a_s1, a_s2, a_stall); end
    checks++; if (b_s1 !== 2'd1 || b_s2 !== 2'd0 || b_stall !== 1'b0) begin errors++; $display("FAIL fwd_ex_B got=%0d/%0d st=%0b exp=1/0 st=0", b_s1, b_s2, b_stall); end
    drain();
  endtask

  task automatic test_x0();
    drive(add_i(5'd5, 5'd1, 5'd2), 1'b1, 1'b0);
    drive(NOP, 1'b1, 1'b0);
    drive(sub_i(5'd7, 5'd0, 5'd5), 1'b1, 1'b0);
    checks++; if (a_s1 !== 2'd0 || a_s2 !== 2'd2) begin errors++; $display("FAIL fwd_stage2 got=%0d/%0d exp=0/2", a_s1, a_s2); end
    drain();
    drive(addi_i(5'd0, 5'd1, 12'd1), 1'b1, 1'b0);
    drive(add_i(5'd8, 5'd0, 5'd0), 1'b1, 1'b0);
    checks++; if (a_s1 !== 2'd0 || a_s2 !== 2'd0) begin errors++; $display("FAIL x0_no_fwd got=%0d/%0d exp=0/0", a_s1, a_s2); end
    drain();
  endtask

  task automatic test_load_use();
    drive(lw_i(5'd5, 5'd1), 1'b1, 1'b0);
    drive(add_i(5'd6, 5'd5, 5'd5), 1'b1, 1'b0);
    checks++; if (a_stall !== 1'b1 || a_s1 !== 2'd0 || a_s2 !== 2'd0) begin errors++; $display("FAIL lu_c1_A got st=%0b sel=%0d/%0d exp st=1 sel=0/0", a_stall, a_s1, a_s2); end
    checks++; if (b_stall !== 1'b1) begin errors++; $display("FAIL lu_c1_B got st=%0b exp st=1", b_stall); end
    drive(add_i(5'd6, 5'd5, 5'd5), 1'b1, 1'b0);
    checks++; if (a_stall !== 1'b0 || a_s1 !== 2'd2 || a_s2 !== 2'd2) begin errors++; $display("FAIL lu_c2_A got st=%0b sel=%0d/%0d exp st=0 sel=2/2", a_stall, a_s1, a_s2); end
    checks++; if (b_stall !== 1'b1 || b_s1 !== 2'd0) begin errors++; $display("FAIL lu_c2_B got st=%0b sel=%0d exp st=1 sel=0", b_stall, b_s1); end
    drive(add_i(5'd6, 5'd5, 5'd5), 1'b1, 1'b0);
    checks++; if (b_stall !== 1'b0 || b_s1 !== 2'd3 || b_s2 !== 2'd3) begin errors++; $display("FAIL lu_c3_B got st=%0b sel=%0d/%0d exp st=0 sel=3/3", b_stall, b_s1, b_s2); end
    drain();
  endtask

  task automatic test_redirect();
    drive(lw_i(5'd5, 5'd1), 1'b1, 1'b0);
    drive(add_i(5'd7, 5'd5, 5'd5), 1'b1, 1'b1);
    checks++; if (a_fif !== 1'b1 || a_fid !== 1'b1) begin errors++; $display("FAIL redir_flush got=%0b/%0b exp=1/1", a_fif, a_fid); end
    checks++; if (a_stall !== 1'b0 || b_stall !== 1'b0) begin errors++; $display("FAIL redir_overrides_stall got=%0b/%0b exp=0/0", a_stall, b_stall); end
    checks++; if (a_s1 !== 2'd1) begin errors++; $display("FAIL redir_sel got=%0d exp=1", a_s1); end
    drive(add_i(5'd8, 5'd7, 5'd0), 1'b1, 1'b0);
    checks++; if (a_s1 !== 2'd0 || b_s1 !== 2'd0) begin errors++; $display("FAIL redir_bubble got=%0d/%0d exp=0/0", a_s1, b_s1); end
    checks++; if (a_fif !== 1'b0) begin errors++; $display("FAIL redir_flush_drop got=%0b exp=0", a_fif); end
    drain();
  endtask

  task automatic test_store_youngest();
    drive(sw_i(5'd5, 5'd2), 1'b1, 1'b0);
    drive(add_i(5'd9, 5'd5, 5'd0), 1'b1, 1'b0);
    checks++; if (a_s1 !== 2'd0 || a_s2 !== 2'd0) begin errors++; $display("FAIL store_no_fwd got=%0d/%0d exp=0/0", a_s1, a_s2); end
    drain();
    drive(add_i(5'd5, 5'd1, 5'd2), 1'b1, 1'b0);
    drive(add_i(5'd5, 5'd3, 5'd4), 1'b1, 1'b0);
    drive(add_i(5'd10, 5'd5, 5'd0), 1'b1, 1'b0);
    checks++; if (a_s1 !== 2'd1 || b_s1 !== 2'd1) begin errors++; $display("FAIL youngest_wins got=%0d/%0d exp=1/1", a_s1, b_s1); end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    drive(lw_i(5'd5, 5'd1), 1'b1, 1'b0);
    drive(add_i(5'd6, 5'd5, 5'd5), 1'b1, 1'b0);
    checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL mid_pre_stall got=%0b exp=1", a_stall); end
    rst_n = 1'b0;
    #1;
    checks++; if (a_stall !== 1'b0 || b_stall !== 1'b0) begin errors++; $display("FAIL mid_rst_stall got=%0b/%0b exp=0/0", a_stall, b_stall); end
    checks++; if (a_s1 !== 2'd0 || a_s2 !== 2'd0 || b_s1 !== 2'd0 || b_s2 !== 2'd0) begin errors++; $display("FAIL mid_rst_sel got=%0d/%0d/%0d/%0d exp=0", a_s1, a_s2, b_s1, b_s2); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(add_i(5'd6, 5'd5, 5'd5), 1'b1, 1'b0);
    checks++; if (a_s1 !== 2'd0 || b_s1 !== 2'd0 || a_stall !== 1'b0) begin errors++; $display("FAIL post_rst_no_fwd got=%0d/%0d st=%0b exp=0/0 st=0", a_s1, b_s1, a_stall); end
    drain();
  endtask

  task automatic test_stats();
    logic [31:0] exp_a, exp_b, exp_f;
    @(negedge clk); rst_n = 1'b0; id_valid = 1'b0; ex_redirect = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(lw_i(5'd5, 5'd1), 1'b1, 1'b0);
      repeat (3) drive(add_i(5'd6, 5'd5, 5'd5), 1'b1, 1'b0);
      drain();
    end
    drive(NOP, 1'b0, 1'b1);
    drive(NOP, 1'b0, 1'b1);
    drive(NOP, 1'b0, 1'b0);
`ifdef HAZARD_STATS_EN
    exp_a = 32'd3; exp_b = 32'd6; exp_f = 32'd2;
`else
    exp_a = 32'd0; exp_b = 32'd0; exp_f = 32'd0;
`endif
    checks++; if (a_sc !== exp_a) begin errors++; $display("FAIL stall_cnt_A got=%0d exp=%0d", a_sc, exp_a); end
    checks++; if (b_sc !== exp_b) begin errors++; $display("FAIL stall_cnt_B got=%0d exp=%0d", b_sc, exp_b); end
    checks++; if (a_fc !== exp_f || b_fc !== exp_f) begin errors++; $display("FAIL flush_cnt got=%0d/%0d exp=%0d", a_fc, b_fc, exp_f); end
  endtask

  // Reference model: the last three issue slots, as seen from decode.
  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       ld;
  } slot_t;

  task automatic test_random();
    slot_t       hist [2][4];
    int          m_stalls [2];
    int          m_flush [2];
    logic [31:0] rnd, inst, exp_sc, exp_fc;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    bit          v, r, wr, u1, u2, ld, haz, est;
    int          e1, e2, lat;
    logic [1:0]  g1, g2;
    logic        gst;
    logic [31:0] gsc, gfc;
    @(negedge clk); rst_n = 1'b0; id_valid = 1'b0; ex_redirect = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_stalls[d] = 0; m_flush[d] = 0;
      for (int k = 0; k < 4; k++) begin hist[d][k].v = 0; hist[d][k].rd = 0; hist[d][k].ld = 0; end
    end
    for (int n = 0; n < 300; n++) begin
      rnd = $urandom;
      case ($urandom_range(0, 8))
        0: op = 7'b0110111; 1: op = 7'b0010111; 2: op = 7'b1101111;
        3: op = 7'b1100111; 4: op = 7'b1100011; 5: op = 7'b0000011;
        6: op = 7'b0100011; 7: op = 7'b0010011; default: op = 7'b0110011;
      endcase
      inst = {rnd[31:25], 2'b00, rnd[22:20], 2'b00, rnd[17:15], rnd[14:12], 2'b00, rnd[9:7], op};
      v = ($urandom_range(0, 9) < 8);
      r = ($urandom_range(0, 9) == 0);
      drive(inst, v, r);
      rd = inst[11:7]; rs1 = inst[19:15]; rs2 = inst[24:20];
      wr = !(op == 7'b0100011 || op == 7'b1100011) && rd != 0;
      u1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
      u2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
      ld = (op == 7'b0000011);
      for (int d = 0; d < 2; d++) begin
        lat = d + 1;
        e1 = 0; e2 = 0; haz = 0;
        for (int k = 1; k <= 3; k++) begin
          if (e1 == 0 && u1 && rs1 != 0 && hist[d][k].v && hist[d][k].rd == rs1) begin
            e1 = k; if (hist[d][k].ld && k <= lat) haz = 1;
          end
          if (e2 == 0 && u2 && rs2 != 0 && hist[d][k].v && hist[d][k].rd == rs2) begin
            e2 = k; if (hist[d][k].ld && k <= lat) haz = 1;
          end
        end
        est = v && !r && haz;
        if (est) begin e1 = 0; e2 = 0; end
        g1  = (d == 0) ? a_s1 : b_s1;
        g2  = (d == 0) ? a_s2 : b_s2;
        gst = (d == 0) ? a_stall : b_stall;
        gsc = (d == 0) ? a_sc : b_sc;
        gfc = (d == 0) ? a_fc : b_fc;
`ifdef HAZARD_STATS_EN
        exp_sc = 32'(m_stalls[d]); exp_fc = 32'(m_flush[d]);
`else
        exp_sc = 32'd0; exp_fc = 32'd0;
`endif
        checks++; if (g1 !== 2'(e1) || g2 !== 2'(e2)) begin errors++; $display("FAIL rnd_sel n=%0d dut=%0d got=%0d/%0d exp=%0d/%0d", n, d, g1, g2, e1, e2); end
        checks++; if (gst !== est) begin errors++; $display("FAIL rnd_stall n=%0d dut=%0d got=%0b exp=%0b", n, d, gst, est); end
        checks++; if (gsc !== exp_sc || gfc !== exp_fc) begin errors++; $display("FAIL rnd_cnt n=%0d dut=%0d got=%0d/%0d exp=%0d/%0d", n, d, gsc, gfc, exp_sc, exp_fc); end
        if (est) m_stalls[d]++;
        if (r) m_flush[d]++;
        for (int k = 3; k >= 2; k--) hist[d][k] = hist[d][k-1];
        hist[d][1].v  = v && !est && !r && wr;
        hist[d][1].rd = rd;
        hist[d][1].ld = ld;
      end
      checks++; if (a_fif !== r || a_fid !== r || b_fif !== r) begin errors++; $display("FAIL rnd_flush n=%0d got=%0b/%0b/%0b exp=%0b", n, a_fif, a_fid, b_fif, r); end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_x0();
    test_load_use();
    test_redirect();
    test_store_youngest();
    test_reset_mid_stall();
    test_stats();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
